// File: rtl/time_bus_reader.sv
// Read-side master of the shared 6-bit time databus: bursts each time register into a shadow frame and
// scans the committed frame onto a multiplexed active-low 7-segment display (TIME_BUS_READER_LZ_BLANK_EN blanks hour/day/month leading zeros).
module time_bus_reader #(
    parameter int REFRESH_DIV = 1000,
    parameter int SCAN_DIV    = 50,
    parameter int NFIELD      = 5
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                bus_gnt,
    input  logic [5:0]          databus,
    output logic                bus_req,
    output logic [NFIELD-1:0]   rd_en,
    output logic                frame_valid,
    output logic [6:0]          seg_n,
    output logic [2*NFIELD-1:0] an_n
);
    localparam int NDIG = 2 * NFIELD;
    localparam int RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW   = (NFIELD > 1) ? $clog2(NFIELD) : 1;
    localparam int DW   = $clog2(NDIG);

    localparam logic [RW-1:0] REFRESH_LOAD = RW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SCAN_LOAD    = SW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] LAST_FIELD   = FW'(NFIELD - 1);
    localparam logic [DW-1:0] LAST_DIGIT   = DW'(NDIG - 1);

    typedef enum logic [2:0] {IDLE, REQ, DRIVE, LATCH, COMMIT} state_t;

    state_t          state, state_nx;
    logic [RW-1:0]   refresh_cnt;
    logic [FW-1:0]   field;
    logic [5:0]      shadow [NFIELD];
    logic [5:0]      disp   [NFIELD];
    logic [SW-1:0]   scan_cnt;
    logic [DW-1:0]   digit;
    logic            lit;
    logic            on_bus;
    logic [FW-1:0]   field_sel;
    logic [7:0]      bcd;
    logic [3:0]      code;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] r;
        t = 4'd0;
        r = v;
        for (int k = 6; k >= 1; k--) begin
            if (t == 4'd0 && v >= 6'(k * 10)) begin
                t = 4'(k);
                r = v - 6'(k * 10);
            end
        end
        return {t, r[3:0]};
    endfunction

    // gfedcba, active-low; codes above 9 blank the digit
    function automatic logic [6:0] seg_decode(input logic [3:0] c);
        case (c)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) state <= IDLE;
        else          state <= state_nx;
    end

    // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (refresh_cnt == '0) state_nx = REQ;
            REQ:     if (bus_gnt) state_nx = DRIVE;
            DRIVE:   state_nx = bus_gnt ? LATCH : REQ;
            LATCH: begin
                if (!bus_gnt)                 state_nx = REQ;
                else if (field == LAST_FIELD) state_nx = COMMIT;
                else                          state_nx = DRIVE;
            end
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant gates rd_en combinationally so a lost grant releases the bus in the same cycle
    always_comb begin
        on_bus      = (state == DRIVE || state == LATCH) && bus_gnt;
        bus_req     = (state != IDLE);
        frame_valid = (state == COMMIT);
        rd_en       = on_bus ? (NFIELD'(1) << field) : '0;
    end

    // NOTE: shadow and display arrays are reset because the display must show zeros after clear.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            refresh_cnt <= REFRESH_LOAD;
            field       <= '0;
            for (int i = 0; i < NFIELD; i++) begin
                shadow[i] <= '0;
                disp[i]   <= '0;
            end
        end else begin
            if (state == IDLE) begin
                if (refresh_cnt == '0) begin
                    refresh_cnt <= REFRESH_LOAD;
                    field       <= '0;
                end else begin
                    refresh_cnt <= refresh_cnt - RW'(1);
                end
            end
            if (state == LATCH && bus_gnt) begin
                shadow[field] <= databus;
                if (field != LAST_FIELD) field <= field + FW'(1);
            end
            if (state == COMMIT) begin
                for (int i = 0; i < NFIELD; i++) disp[i] <= shadow[i];
            end
        end
    end

    // Free-running scan; lit stays low until the first interval so anodes start all-off
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            scan_cnt <= SCAN_LOAD;
            digit    <= '0;
            lit      <= 1'b0;
        end else if (scan_cnt == '0) begin
            scan_cnt <= SCAN_LOAD;
            if (!lit)                     lit   <= 1'b1;
            else if (digit == LAST_DIGIT) digit <= '0;
            else                          digit <= digit + DW'(1);
        end else begin
            scan_cnt <= scan_cnt - SW'(1);
        end
    end

    always_comb begin
        field_sel = FW'(digit >> 1);
        bcd       = to_bcd(disp[field_sel]);
        code      = digit[0] ? bcd[7:4] : bcd[3:0];
`ifdef TIME_BUS_READER_LZ_BLANK_EN
        if (digit[0] && field_sel >= FW'(2) && bcd[7:4] == 4'd0) code = 4'hF;
`else
        code = code;
`endif
        seg_n = lit ? seg_decode(code) : 7'b1111111;
        an_n  = lit ? ~(NDIG'(1) << digit) : '1;
    end
endmodule

// File: tb/tb_time_bus_reader.sv
// Self-checking bench for time_bus_reader: table of register frames plus hand-written burst, grant-loss and reset sequences.
module tb_time_bus_reader;
    localparam int RDIV = 8;
    localparam int SDIV = 2;
    localparam int NF   = 5;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        bus_gnt;
    logic [5:0]  databus;
    logic        bus_req;
    logic [4:0]  rd_en;
    logic        frame_valid;
    logic [6:0]  seg_n;
    logic [9:0]  an_n;

    logic [5:0]  regs [NF];
    logic [39:0] sb_q [$];
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [5:0]  sec, min, hour, day, month;
        logic [39:0] digits;  // expected BCD, month tens .. sec ones
    } vec_t;
    vec_t vecs [4];

    time_bus_reader #(.REFRESH_DIV(RDIV), .SCAN_DIV(SDIV), .NFIELD(NF)) dut (
        .clk(clk), .clear_n(clear_n), .bus_gnt(bus_gnt), .databus(databus),
        .bus_req(bus_req), .rd_en(rd_en), .frame_valid(frame_valid),
        .seg_n(seg_n), .an_n(an_n)
    );

    always #5 clk = ~clk;

    // Time registers: the enabled one drives the bus
    always_comb begin
        databus = 6'd0;
        for (int i = 0; i < NF; i++) if (rd_en[i]) databus = regs[i];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (clear_n === 1'b1) begin
            logic ok;
            ok = ($countones(rd_en) <= 1) && !(rd_en != 5'd0 && bus_gnt !== 1'b1);
            check("rd_en_legal", ok, 1'b1);
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] c);
        case (c)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [39:0] bcd, input int d);
        logic [3:0] c;
        c = bcd[4*d +: 4];
`ifdef TIME_BUS_READER_LZ_BLANK_EN
        if (d % 2 == 1 && d >= 5 && c == 4'd0) c = 4'hF;
`endif
        return seg_of(c);
    endfunction

    function automatic logic [39:0] bcd_pack(input logic [5:0] s, m, h, dy, mo);
        logic [5:0] v [5];
        logic [39:0] r;
        v[0] = s; v[1] = m; v[2] = h; v[3] = dy; v[4] = mo;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[8*i +: 4]     = 4'(v[i] % 10);
            r[8*i + 4 +: 4] = 4'(v[i] / 10);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_regs(input logic [5:0] s, m, h, dy, mo);
        regs[0] = s; regs[1] = m; regs[2] = h; regs[3] = dy; regs[4] = mo;
    endtask

    task automatic wait_fv(input string name, output int n);
        n = 0;
        while (frame_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(name, frame_valid, 1'b1);
    endtask

    task automatic check_display(input string name, input logic [39:0] exp);
        for (int d = 0; d < 10; d++) begin
            logic [9:0] an_exp;
            int n;
            an_exp = ~(10'd1 << d);
            n = 0;
            while (an_n !== an_exp && n < 40) begin
                tick();
                n++;
            end
            check($sformatf("%s_digit%0d", name, d), {an_n, seg_n}, {an_exp, exp_seg(exp, d)});
        end
    endtask

    task automatic sb_pop_check(input string name);
        logic [39:0] exp;
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            exp = sb_q.pop_front();
            check_display(name, exp);
        end
    endtask

    task automatic count_to_req(input string name);
        int n;
        n = 0;
        while (bus_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check(name, n, RDIV);
    endtask

    initial begin
        int n;
        logic [4:0]  rd_seq [10];
        logic [39:0] old_exp, new_exp;
        logic [9:0]  prev_an;

        vecs[0] = '{6'd45, 6'd30, 6'd12, 6'd25, 6'd11, 40'h1125123045};
        vecs[1] = '{6'd63, 6'd0,  6'd9,  6'd1,  6'd12, 40'h1201090063};
        vecs[2] = '{6'd59, 6'd59, 6'd23, 6'd31, 6'd12, 40'h1231235959};
        vecs[3] = '{6'd7,  6'd8,  6'd0,  6'd60, 6'd1,  40'h0160000807};
        rd_seq  = '{5'b00001, 5'b00001, 5'b00010, 5'b00010, 5'b00100,
                    5'b00100, 5'b01000, 5'b01000, 5'b10000, 5'b10000};

        // Reset state
        bus_gnt = 1'b1;
        clear_n = 1'b0;
        set_regs(vecs[0].sec, vecs[0].min, vecs[0].hour, vecs[0].day, vecs[0].month);
        repeat (3) tick();
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_rd_en", rd_en, 5'd0);
        check("rst_frame_valid", frame_valid, 1'b0);
        check("rst_an_n", an_n, 10'h3FF);
        check("rst_seg_n", seg_n, 7'h7F);

        // First burst: timing, rd_en walk, commit
        sb_q.push_back(vecs[0].digits);
        @(negedge clk);
        clear_n = 1'b1;
        count_to_req("first_req_cycles");
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("burst_rd_en_%0d", k), {frame_valid, rd_en}, {1'b0, rd_seq[k]});
        end
        tick();
        check("commit_cycle", {frame_valid, bus_req, rd_en}, {1'b1, 1'b1, 5'd0});
        tick();
        check("after_commit", {frame_valid, bus_req}, 2'b00);
        sb_pop_check("burst0");

        // Table-driven frames
        for (int i = 1; i < 4; i++) begin
            wait_fv($sformatf("sync_fv_%0d", i), n);
            set_regs(vecs[i].sec, vecs[i].min, vecs[i].hour, vecs[i].day, vecs[i].month);
            sb_q.push_back(vecs[i].digits);
            tick();
            wait_fv($sformatf("vec_fv_%0d", i), n);
            tick();
            sb_pop_check($sformatf("vec%0d", i));
        end

        // Grant drop during LATCH of hour
        wait_fv("gd_sync", n);
        set_regs(6'd10, 6'd20, 6'd12, 6'd5, 6'd6);
        n = 0;
        while (rd_en !== 5'b00100 && n < 100) begin
            tick();
            n++;
        end
        check("gd_drive_hour", rd_en, 5'b00100);
        tick();
        check("gd_latch_hour", rd_en, 5'b00100);
        bus_gnt = 1'b0;
        #1;
        check("gd_rd_en_drop", {bus_req, rd_en}, {1'b1, 5'd0});
        regs[2] = 6'd13;
        regs[0] = 6'd33;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("gd_hold_%0d", k), {frame_valid, bus_req, rd_en}, {1'b0, 1'b1, 5'd0});
        end
        bus_gnt = 1'b1;
        sb_q.push_back(bcd_pack(6'd10, 6'd20, 6'd13, 6'd5, 6'd6));
        wait_fv("gd_fv", n);
        check("gd_regrant_cycles", n, 7);
        tick();
        bus_gnt = 1'b0;
        sb_pop_check("gd_frame");

        // Wait-for-grant: old frame held while request is pending
        bus_gnt = 1'b1;
        old_exp = bcd_pack(regs[0], regs[1], regs[2], regs[3], regs[4]);
        wait_fv("wfg_sync", n);
        tick();
        bus_gnt = 1'b0;
        set_regs(6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
        new_exp = bcd_pack(6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
        n = 0;
        while (bus_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("wfg_wait_%0d", k), {frame_valid, bus_req, rd_en}, {1'b0, 1'b1, 5'd0});
        end
        check_display("wfg_old", old_exp);
        check("wfg_still_req", bus_req, 1'b1);
        bus_gnt = 1'b1;
        sb_q.push_back(new_exp);
        wait_fv("wfg_fv", n);
        tick();
        sb_pop_check("wfg_new");

        // Reset mid-DRIVE
        n = 0;
        while (rd_en !== 5'b00001 && n < 100) begin
            tick();
            n++;
        end
        check("mr_drive", rd_en, 5'b00001);
        clear_n = 1'b0;
        #1;
        check("mr_outputs", {frame_valid, bus_req, rd_en, an_n, seg_n}, {1'b0, 1'b0, 5'd0, 10'h3FF, 7'h7F});
        bus_gnt = 1'b0;
        tick();
        tick();
        @(negedge clk);
        clear_n = 1'b1;
        count_to_req("mr_req_cycles");
        check_display("mr_zero", 40'h0);

        // Scan wrap
        prev_an = an_n;
        n = 0;
        while (!(an_n === 10'h3FE && prev_an !== 10'h3FE) && n < 60) begin
            prev_an = an_n;
            tick();
            n++;
        end
        check("scan_start", an_n, 10'h3FE);
        for (int k = 1; k <= 20; k++) begin
            logic [9:0] an_exp;
            tick();
            an_exp = ~(10'd1 << ((k / 2) % 10));
            check($sformatf("scan_walk_%0d", k), an_n, an_exp);
        end

        bus_gnt = 1'b1;
        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
